// File: rtl/i2c_slave.sv
// Fixed-address I2C target: oversampled SCL/SDA, START/STOP detection,
// write bytes out on or_rx_data, read bytes serialised from iw_tx_data.
//
// Ports:
//   iw_clk       system clock, at least 10x the SCL rate
//   iw_reset     synchronous active-high reset
//   io_i2c_scl   bus clock, sampled only (no clock stretching)
//   io_i2c_sda   bus data, open-drain (0 or z)
//   iw_tx_data   byte returned on a read, latched when ow_tx_req pulses
//   ow_tx_req    1-cycle pulse when iw_tx_data is latched
//   or_rx_data   last complete byte received in a write
//   or_rx_valid  1-cycle pulse when or_rx_data updates
//   or_busy      high from an addressed START until STOP or NACK
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       iw_clk,
    input  logic       iw_reset,
    inout  wire        io_i2c_scl,
    inout  wire        io_i2c_sda,
    input  logic [7:0] iw_tx_data,
    output logic       ow_tx_req,
    output logic [7:0] or_rx_data,
    output logic       or_rx_valid,
    output logic       or_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX,
        S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       drive_q, drive_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       busy_d, rx_valid_d, tx_req_d;
    logic [7:0] rx_data_d;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // SCL is observed only; SDA is pulled low when drive_q is set
    assign io_i2c_scl = 1'bz;
    assign io_i2c_sda = drive_q ? 1'b0 : 1'bz;

    wire scl_rise = scl_s2 & ~scl_h;
    wire scl_fall = ~scl_s2 & scl_h;
    wire scl_high = scl_s2 & scl_h;
    wire bus_start = scl_high & sda_h & ~sda_s2;
    wire bus_stop = scl_high & ~sda_h & sda_s2;

    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            scl_s1      <= 1'b1;
            scl_s2      <= 1'b1;
            scl_h       <= 1'b1;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
            sda_h       <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            drive_q     <= 1'b0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            or_busy     <= 1'b0;
            or_rx_data  <= 8'h00;
            or_rx_valid <= 1'b0;
            ow_tx_req   <= 1'b0;
        end else begin
            scl_s1      <= io_i2c_scl;
            scl_s2      <= scl_s1;
            scl_h       <= scl_s2;
            sda_s1      <= io_i2c_sda;
            sda_s2      <= sda_s1;
            sda_h       <= sda_s2;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            drive_q     <= drive_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            or_busy     <= busy_d;
            or_rx_data  <= rx_data_d;
            or_rx_valid <= rx_valid_d;
            ow_tx_req   <= tx_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        drive_d    = drive_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        busy_d     = or_busy;
        rx_data_d  = or_rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (bus_start) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            drive_d = 1'b0;
            phase_d = 1'b0;
        end else if (bus_stop) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            drive_d = 1'b0;
            phase_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_WAIT_STOP: drive_d = 1'b0;
                S_ADDR: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_s2};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rw_d    = sda_s2;
                        phase_d = 1'b0;
                        // first seven bits shifted in are the address
                        if (shift_q[6:0] == ADDR) begin
                            busy_d  = 1'b1;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        drive_d = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = 3'd0;
                        if (rw_q) begin
                            tx_req_d = 1'b1;
                            tx_d     = iw_tx_data;
                            drive_d  = ~iw_tx_data[7];
                            state_d  = S_TX;
                        end else begin
                            drive_d = 1'b0;
                            shift_d = 8'h00;
                            state_d = S_RX;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_s2};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_s2};
                        rx_valid_d = 1'b1;
                        phase_d    = 1'b0;
                        state_d    = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        drive_d = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        drive_d = 1'b0;
                        phase_d = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = S_RX;
                    end
                end
                S_TX: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        drive_d = 1'b0;
                        cnt_d   = 3'd0;
                        phase_d = 1'b0;
                        state_d = S_TX_ACK;
                    end else begin
                        drive_d = ~tx_q[6];
                        tx_d    = {tx_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                S_TX_ACK: begin
                    // phase_q set once the master has ACKed on the rise
                    if (!phase_q && scl_rise) begin
                        if (sda_s2) begin
                            busy_d  = 1'b0;
                            state_d = S_WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (phase_q && scl_fall) begin
                        tx_req_d = 1'b1;
                        tx_d     = iw_tx_data;
                        drive_d  = ~iw_tx_data[7];
                        phase_d  = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = S_TX;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, scoreboard queues, and
// randomized transactions against a byte-level reference model.
module tb_i2c_slave;

    localparam logic [6:0] SLV = 7'h50;
    localparam int Q = 8;

    logic       iw_clk = 1'b0;
    logic       iw_reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] iw_tx_data;
    logic       ow_tx_req;
    logic [7:0] or_rx_data;
    logic       or_rx_valid;
    logic       or_busy;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);
    assign scl = m_scl ? 1'bz : 1'b0;
    assign sda = m_sda ? 1'bz : 1'b0;

    i2c_slave #(.ADDR(SLV)) dut (
        .iw_clk(iw_clk),
        .iw_reset(iw_reset),
        .io_i2c_scl(scl),
        .io_i2c_sda(sda),
        .iw_tx_data(iw_tx_data),
        .ow_tx_req(ow_tx_req),
        .or_rx_data(or_rx_data),
        .or_rx_valid(or_rx_valid),
        .or_busy(or_busy)
    );

    always #5 iw_clk = ~iw_clk;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] last_rx = 8'h00;
    logic [7:0] tx_mem[0:255];
    int tx_wr = 0;
    int tx_ptr = 0;
    logic rxv_prev = 1'b0;
    logic txr_prev = 1'b0;

    assign iw_tx_data = tx_mem[tx_ptr[7:0]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: pops expected write bytes, advances the tx stream
    always @(negedge iw_clk) begin
        if (or_rx_valid) begin
            if (exp_rx.size() == 0)
                chk("rx_unexpected", 1, 0);
            else
                chk("rx_data", {24'h0, or_rx_data}, {24'h0, exp_rx.pop_front()});
            if (rxv_prev) chk("rx_valid_width", 2, 1);
        end
        if (ow_tx_req) begin
            if (txr_prev) chk("tx_req_width", 2, 1);
            else tx_ptr = tx_ptr + 1;
        end
        rxv_prev = or_rx_valid;
        txr_prev = ow_tx_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iw_clk);
        #1;
    endtask

    task automatic m_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic wr_bit(input logic b);
        m_sda = b; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic rd_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = sda;
        tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(~ack);
    endtask

    // model: a write of n bytes; each byte is expected only if addressed
    task automatic do_write(input logic [6:0] a, input logic [7:0] d[$]);
        logic ack;
        logic hit;
        hit = (a == SLV);
        m_start();
        wr_byte({a, 1'b0}, ack);
        chk("wr_addr_ack", {31'h0, ack}, {31'h0, hit});
        chk("wr_busy", {31'h0, or_busy}, {31'h0, hit});
        foreach (d[i]) begin
            if (hit) begin
                exp_rx.push_back(d[i]);
                last_rx = d[i];
            end
            wr_byte(d[i], ack);
            chk("wr_data_ack", {31'h0, ack}, {31'h0, hit});
        end
        m_stop();
        chk("wr_busy_after_stop", {31'h0, or_busy}, 32'h0);
        chk("rx_pending", exp_rx.size(), 0);
    endtask

    // model: n bytes come back in the order supplied; last one NACKed
    task automatic do_read(input logic [6:0] a, input logic [7:0] d[$]);
        logic ack;
        logic hit;
        logic [7:0] got;
        hit = (a == SLV);
        foreach (d[i]) begin
            tx_mem[tx_wr[7:0]] = d[i];
            tx_wr++;
        end
        m_start();
        wr_byte({a, 1'b1}, ack);
        chk("rd_addr_ack", {31'h0, ack}, {31'h0, hit});
        if (hit) begin
            chk("rd_busy", {31'h0, or_busy}, 32'h1);
            foreach (d[i]) begin
                rd_byte(i != d.size() - 1, got);
                chk("rd_data", {24'h0, got}, {24'h0, d[i]});
            end
            chk("rd_busy_after_nack", {31'h0, or_busy}, 32'h0);
        end else begin
            tx_wr = tx_wr - d.size();
        end
        m_stop();
        chk("tx_req_count", tx_ptr, tx_wr);
    endtask

    initial begin
        logic [7:0] q[$];
        logic ack;
        logic [6:0] a;
        tx_mem[0] = 8'h00;
        iw_reset = 1'b1;
        tick(5);
        chk("reset_sda", {31'h0, sda}, 32'h1);
        chk("reset_busy", {31'h0, or_busy}, 32'h0);
        chk("reset_rx_data", {24'h0, or_rx_data}, 32'h0);
        chk("reset_pulses", {30'h0, or_rx_valid, ow_tx_req}, 32'h0);
        iw_reset = 1'b0;
        tick(4);

        q = '{8'hAA};
        do_write(SLV, q);
        chk("rx_data_aa", {24'h0, or_rx_data}, 32'hAA);
        q = '{8'hFF};
        do_write(7'h51, q);
        chk("mismatch_keeps", {24'h0, or_rx_data}, 32'hAA);

        q = '{8'h3C};
        do_read(SLV, q);
        q = '{8'h3C, 8'hC3};
        do_read(SLV, q);

        // abort after four data bits
        m_start();
        wr_byte({SLV, 1'b0}, ack);
        chk("abort_addr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 4; i++) wr_bit(1'($urandom));
        m_stop();
        chk("abort_rx_hold", {24'h0, or_rx_data}, {24'h0, last_rx});

        // partial byte, repeated START, then 0x55
        m_start();
        wr_byte({SLV, 1'b0}, ack);
        for (int i = 0; i < 3; i++) wr_bit(1'($urandom));
        m_start();
        wr_byte({SLV, 1'b0}, ack);
        chk("rs_addr_ack", {31'h0, ack}, 32'h1);
        exp_rx.push_back(8'h55);
        last_rx = 8'h55;
        wr_byte(8'h55, ack);
        chk("rs_data_ack", {31'h0, ack}, 32'h1);
        m_stop();
        chk("rs_rx_data", {24'h0, or_rx_data}, 32'h55);

        for (int t = 0; t < 14; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) do_read(a, q);
            else do_write(a, q);
        end

        // reset while the slave is pulling SDA low for the ACK
        m_start();
        for (int i = 7; i >= 0; i--) wr_bit(i == 0 ? 1'b0 : SLV[i - 1]);
        m_sda = 1'b1;
        tick(1);
        chk("ack_driven", {31'h0, sda}, 32'h0);
        iw_reset = 1'b1;
        tick(1);
        chk("reset_release", {31'h0, sda}, 32'h1);
        tick(4);
        m_scl = 1'b1;
        tick(2);
        iw_reset = 1'b0;
        tick(Q);
        chk("post_reset_busy", {31'h0, or_busy}, 32'h0);
        chk("post_reset_rx", {24'h0, or_rx_data}, 32'h0);
        chk("final_rx_queue", exp_rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Fixed-address I2C target that sits on the bus directly downstream of i2c_master and consumes the SCL/SDA traffic it produces. It oversamples the bus with the system clock and detects START and STOP. On a matching address it ACKs, then either receives write bytes into a parallel output or serialises a supplied byte for reads. Used as the bus-level companion and loopback partner for i2c_master in integration benches.

Parameters:
ADDR, 7'h50, 7-bit target address this block responds to.

Ports:
iw_clk  input  1  system clock; must be ≥10× the SCL frequency.
iw_reset  input  1  synchronous, active-high reset.
io_i2c_scl  inout  1  bus clock; sampled only, never driven (held z; no clock stretching).
io_i2c_sda  inout  1  bus data; open-drain, driven 1'b0 or z only.
iw_tx_data  input  8  byte returned on a read; latched at ow_tx_req.
ow_tx_req  output  1  1-cycle pulse when iw_tx_data is latched for transmission.
or_rx_data  output  8  last byte received in a write transfer.
or_rx_valid  output  1  1-cycle pulse when or_rx_data updates.
or_busy  output  1  high from an addressed START until STOP or NACK release.

Behaviour:
- Reset (synchronous, active-high, iw_clk): state IDLE; SDA released (z); or_rx_data=8'h00; or_rx_valid=0; ow_tx_req=0; or_busy=0; bit counter=0; synchroniser flops=1. Reset mid-transfer releases SDA on the first reset cycle.
- Input path: SCL and SDA each pass a 2-FF synchroniser plus a history flop. Edges are detected on the synchronised values, so an edge is acted on 3 iw_clk cycles after it occurs on the pin.
- Bus events on synchronised signals:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - SCL rise: sample SDA.
  - SCL fall: update the SDA drive.
- START from any state, including a repeated START, goes to ADDR with bit counter=0 and clears the shift register. STOP from any state goes to IDLE, releases SDA and clears or_busy. START and STOP take priority over SCL edges detected in the same cycle.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB-first on SCL rises (7 address bits + R/W). After the 8th rise:
    - Address match: set or_busy, go to ADDR_ACK.
    - No match: go to WAIT_STOP; SDA is never driven.
  - ADDR_ACK: on the next SCL fall, drive SDA=0. On the following SCL fall, release SDA (write) or go to TX (read).
    - Write: go to RX.
    - Read: pulse ow_tx_req, latch iw_tx_data into the tx shifter, drive bit 7 on SDA (0→drive low, 1→release), go to TX.
  - RX: shift 8 bits on SCL rises. After the 8th rise, or_rx_data<=shift value and or_rx_valid pulses for exactly 1 cycle (the cycle after the rise is detected). Go to RX_ACK.
  - RX_ACK: drive SDA=0 on the next SCL fall; release on the following fall; return to RX with counter=0.
  - TX: on each SCL fall, present the next bit (bits 6..0). After the 8th bit's SCL fall, release SDA and go to TX_ACK.
  - TX_ACK: on SCL rise, sample the master response.
    - SDA=0 (ACK): on the next SCL fall, pulse ow_tx_req, latch iw_tx_data, drive its bit 7, go to TX.
    - SDA=1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; ignore SCL edges until STOP→IDLE or START→ADDR. or_busy is cleared on entry from a NACK.
- A STOP or START arriving mid-byte discards the partial byte: no or_rx_valid pulse, or_rx_data unchanged.
- SDA changes are made only on SCL falls and are never driven while SCL=1, so the slave cannot create a false START or STOP.

Test Plan:
- Reset: hold iw_reset 5 cycles with the bus idle (both lines pulled high) → SDA=z, or_busy=0, or_rx_data=8'h00, no pulses.
- Write match: master writes address 0x50, W, then data 8'hAA → slave pulls SDA low in both ACK slots; or_rx_data=8'hAA with exactly one or_rx_valid pulse; or_busy=0 after STOP.
- Address mismatch: master writes to 0x51 → SDA never driven low (NACK seen by master); or_rx_valid never asserts; state returns to IDLE on STOP.
- Read: iw_tx_data=8'h3C, master reads 0x50 then NACKs → one ow_tx_req pulse; SDA bits on SCL rises = 0,0,1,1,1,1,0,0; SDA released in the ACK slot; state WAIT_STOP→IDLE.
- Two-byte read with ACK: iw_tx_data changes 8'h3C→8'hC3 after the first ow_tx_req → second byte = 8'hC3; two ow_tx_req pulses total.
- Abort and reset: STOP after 4 data bits → no or_rx_valid, or_rx_data holds its previous value. Repeated START then a write of 8'h55 → or_rx_data=8'h55. iw_reset asserted while driving an ACK → SDA released the next cycle.
